// File: rtl/io_input_ctrl.sv
// Memory-mapped switch/button input controller: synchroniser, per-channel
// debounce, sticky press events with write-1-to-clear, and a level interrupt.
module io_input_ctrl #(
  parameter int unsigned NUM_SW          = 32,
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned BTN_ACTIVE_LOW  = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_SW-1:0]  i_io_sw,
  input  logic [NUM_BTN-1:0] i_io_btn,
  input  logic [3:0]         i_addr,
  input  logic               i_wr_en,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        o_rdata,
  output logic               o_irq
);

  localparam int unsigned NCH = NUM_SW + NUM_BTN;
  localparam int unsigned CW  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [1:0] REG_SW_STATE  = 2'd0;
  localparam logic [1:0] REG_BTN_STATE = 2'd1;
  localparam logic [1:0] REG_BTN_EVENT = 2'd2;
  localparam logic [1:0] REG_IRQ_EN    = 2'd3;

  logic [NUM_BTN-1:0] btn_in;
  logic [NCH-1:0]     raw;
  logic [NCH-1:0]     sync_q [SYNC_STAGES];
  logic [NCH-1:0]     sync;
  logic [NCH-1:0]     stable_q;
  logic [NCH-1:0]     stable_d;
  logic [CW-1:0]      cnt_q [NCH];
  logic [CW-1:0]      cnt_d [NCH];

  logic [NUM_BTN-1:0] btn_stable;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] event_q;
  logic [NUM_BTN-1:0] event_d;
  logic [NUM_BTN-1:0] event_clr;
  logic [NUM_BTN-1:0] irq_en_q;
  logic               wr_event;
  logic               wr_irq_en;
  logic               unused;

  // Buttons are normalised so that an internal 1 always means pressed.
  assign btn_in = (BTN_ACTIVE_LOW != 0) ? ~i_io_btn : i_io_btn;
  assign raw    = {btn_in, i_io_sw};
  assign sync   = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // A differing level must persist DEBOUNCE_CYCLES cycles; any return restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      cnt_d[ch] = '0;
      if (sync[ch] != stable_q[ch]) begin
        if (cnt_q[ch] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[ch] = sync[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stable_q <= '0;
      for (int unsigned ch = 0; ch < NCH; ch++) cnt_q[ch] <= '0;
    end else begin
      stable_q <= stable_d;
      for (int unsigned ch = 0; ch < NCH; ch++) cnt_q[ch] <= cnt_d[ch];
    end
  end

  assign btn_stable = stable_q[NCH-1:NUM_SW];
  assign btn_rise   = stable_d[NCH-1:NUM_SW] & ~btn_stable;

  assign wr_event  = i_wr_en && (i_addr[3:2] == REG_BTN_EVENT);
  assign wr_irq_en = i_wr_en && (i_addr[3:2] == REG_IRQ_EN);
  assign event_clr = wr_event ? i_wdata[NUM_BTN-1:0] : '0;

  // Set is applied after clear so a same-edge press wins over W1C.
  assign event_d = (event_q & ~event_clr) | btn_rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      event_q  <= '0;
      irq_en_q <= '0;
    end else begin
      event_q <= event_d;
      if (wr_irq_en) irq_en_q <= i_wdata[NUM_BTN-1:0];
    end
  end

  assign o_irq = |(event_q & irq_en_q);

  always_comb begin
    o_rdata = '0;
    case (i_addr[3:2])
      REG_SW_STATE:  o_rdata = 32'(stable_q[NUM_SW-1:0]);
      REG_BTN_STATE: o_rdata = 32'(btn_stable);
      REG_BTN_EVENT: o_rdata = 32'(event_q);
      REG_IRQ_EN:    o_rdata = 32'(irq_en_q);
      default:       o_rdata = '0;
    endcase
  end

  assign unused = ^{i_addr[1:0], i_wdata};

endmodule

// File: tb/tb_io_input_ctrl.sv
// Directed bench for io_input_ctrl with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_io_input_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] sw;
  logic [3:0]  btn;
  logic [3:0]  addr;
  logic        wr_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  io_input_ctrl #(
    .NUM_SW(32), .NUM_BTN(4), .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4), .BTN_ACTIVE_LOW(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_io_sw(sw), .i_io_btn(btn),
    .i_addr(addr), .i_wr_en(wr_en), .i_wdata(wdata),
    .o_rdata(rdata), .o_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  // Presents a write so that it lands on the next rising edge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    wdata = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    sw    = '0;
    btn   = 4'hF;
    addr  = '0;
    wr_en = 1'b0;
    wdata = '0;

    // Reset state and quiet inputs after release
    repeat (3) tick();
    rd("rst_sw", 4'h0, 32'h0);
    rd("rst_btn", 4'h4, 32'h0);
    rd("rst_evt", 4'h8, 32'h0);
    rd("rst_en", 4'hC, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;
    repeat (10) tick();
    rd("post_sw", 4'h0, 32'h0);
    rd("post_btn", 4'h4, 32'h0);
    rd("post_evt", 4'h8, 32'h0);
    check("post_irq", {31'b0, irq}, 32'h0);

    // Switch latency: visible on edge 6, not edge 5
    sw[5] = 1'b1;
    repeat (5) tick();
    rd("sw_edge5", 4'h0, 32'h0);
    tick();
    rd("sw_edge6", 4'h0, 32'h20);
    wr(4'h0, 32'hFFFF_FFFF);
    rd("sw_ro", 4'h0, 32'h20);

    // Bounce rejection on btn2 followed by a real press
    btn = 4'b1011;
    repeat (3) tick();
    btn = 4'hF;
    repeat (8) tick();
    rd("bounce_state", 4'h4, 32'h0);
    rd("bounce_evt", 4'h8, 32'h0);
    btn = 4'b1011;
    repeat (5) tick();
    rd("btn2_edge5", 4'h4, 32'h0);
    tick();
    rd("btn2_state", 4'h4, 32'h4);
    rd("btn2_evt", 4'h8, 32'h4);
    check("btn2_irq_masked", {31'b0, irq}, 32'h0);
    btn = 4'hF;
    repeat (8) tick();
    rd("btn2_rel_state", 4'h4, 32'h0);
    rd("btn2_rel_evt", 4'h8, 32'h4);
    wr(4'h8, 32'h4);
    rd("btn2_w1c", 4'h8, 32'h0);

    // Interrupt enable, mask on the write edge, W1C drop
    wr(4'hC, 32'h2);
    rd("irq_en_rb", 4'hC, 32'h2);
    btn = 4'b1101;
    repeat (5) tick();
    check("irq_edge5", {31'b0, irq}, 32'h0);
    tick();
    rd("btn1_evt", 4'h8, 32'h2);
    check("irq_set", {31'b0, irq}, 32'h1);
    wr(4'hC, 32'h0);
    check("irq_masked", {31'b0, irq}, 32'h0);
    wr(4'hC, 32'h2);
    check("irq_unmasked", {31'b0, irq}, 32'h1);
    wr(4'h8, 32'h2);
    rd("btn1_w1c", 4'h8, 32'h0);
    check("irq_w1c", {31'b0, irq}, 32'h0);
    btn = 4'hF;
    repeat (8) tick();
    rd("btn1_rel_evt", 4'h8, 32'h0);
    check("btn1_rel_irq", {31'b0, irq}, 32'h0);

    // Set/clear collision on the btn0 acceptance edge
    btn = 4'b1110;
    repeat (5) tick();
    wr(4'h8, 32'h1);
    rd("collide_evt", 4'h8, 32'h1);
    rd("collide_state", 4'h4, 32'h1);
    wr(4'h8, 32'h1);
    rd("collide_clr", 4'h8, 32'h0);
    btn = 4'hF;
    repeat (8) tick();

    // Reset mid-debounce on btn3; sw[5] stays high throughout
    btn = 4'b0111;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_irq", {31'b0, irq}, 32'h0);
    rd("midrst_en", 4'hC, 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    rd("midrst_edge5", 4'h4, 32'h0);
    rd("midrst_sw5", 4'h0, 32'h0);
    tick();
    rd("midrst_edge6", 4'h4, 32'h8);
    rd("midrst_sw6", 4'h0, 32'h20);
    rd("midrst_evt", 4'h8, 32'h8);

    // Upper IRQ_EN bits are not writable; enabled pending event raises irq
    wr(4'hC, 32'hFFFF_FFFF);
    rd("irq_en_mask", 4'hC, 32'hF);
    check("irq_btn3", {31'b0, irq}, 32'h1);
    wr(4'h4, 32'h0);
    rd("btn_ro", 4'h4, 32'h8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
